// File: rtl/clock_divider_nch.sv
// rtl/clock_divider_nch.sv - CHANNELS independent divide-by-N clocks with end-of-period ticks
// Optional sync phase alignment is compiled in with `define CLKDIV_PHASE_ALIGN_EN.
module clock_divider_nch #(
    parameter int WIDTH     = 28,
    parameter int CHANNELS  = 4,
    parameter int RESET_DIV = 4
) (
    input  logic                      clock_in,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clock_out,
    output logic [CHANNELS-1:0]       tick
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_n [CHANNELS];
    logic [WIDTH-1:0]    d_q   [CHANNELS];
    logic [WIDTH-1:0]    d_n   [CHANNELS];
    logic [WIDTH-1:0]    p_q   [CHANNELS];
    logic [WIDTH-1:0]    p_n   [CHANNELS];
    logic [CHANNELS-1:0] pv_q;
    logic [CHANNELS-1:0] pv_n;
    logic [CHANNELS-1:0] clock_n;
    logic [CHANNELS-1:0] tick_n;
    logic                sync_act;

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign sync_act = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_act    = 1'b0;
`endif

    always_comb begin
        pv_n    = pv_q;
        clock_n = '0;
        tick_n  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            logic [WIDTH-1:0] slice;
            logic             restart;
            slice    = divisor[i*WIDTH +: WIDTH];
            cnt_n[i] = cnt_q[i];
            d_n[i]   = d_q[i];
            p_n[i]   = p_q[i];
            restart  = !enable[i] || sync_act || (d_q[i] < TWO) || (cnt_q[i] == d_q[i] - ONE);
            if (rst) begin
                cnt_n[i] = '0;
                d_n[i]   = RST_D;
                pv_n[i]  = 1'b0;
            end else if (restart) begin
                // Period boundary (or stopped): a same-cycle load beats the older pending value.
                cnt_n[i] = '0;
                pv_n[i]  = 1'b0;
                if (load[i]) begin
                    d_n[i] = slice;
                end else if (pv_q[i]) begin
                    d_n[i] = p_q[i];
                end
            end else begin
                cnt_n[i] = cnt_q[i] + ONE;
                if (load[i]) begin
                    p_n[i]  = slice;
                    pv_n[i] = 1'b1;
                end
            end
            // Outputs are decoded from next state so the flops reflect the counter in the same cycle.
            clock_n[i] = (d_n[i] >= TWO) && (cnt_n[i] >= (d_n[i] >> 1));
            tick_n[i]  = (d_n[i] >= TWO) && (cnt_n[i] == d_n[i] - ONE);
        end
    end

    always_ff @(posedge clock_in) begin
        cnt_q     <= cnt_n;
        d_q       <= d_n;
        p_q       <= p_n;
        pv_q      <= pv_n;
        clock_out <= clock_n;
        tick      <= tick_n;
    end

endmodule

// File: doc/clock_divider_nch.md
# clock_divider_nch

Multi-channel, parametrised successor to the single-output clock divider: `CHANNELS` independent divide-by-N outputs derived from one input clock, each with its own runtime divisor, enable and period-boundary (glitch-free) divisor update. Each channel also emits a one-cycle `tick` strobe at the end of every output period for use as a clock-enable by downstream logic. The block sits at the top of the timing tree, feeding LED blinkers, baud generators and sample strobes from the board clock.

## Interface
- `WIDTH`, 28, bit width of each divisor and counter
- `CHANNELS`, 4, number of independent divider channels
- `RESET_DIV`, 4, active divisor of every channel after reset; must satisfy 2 ≤ `RESET_DIV` < 2^`WIDTH`
- `clock_in`  input  1  single clock; all logic on its rising edge
- `rst`  input  1  reset; synchronous, active-high
- `enable`  input  `CHANNELS`  per-channel run enable
- `divisor`  input  `CHANNELS*WIDTH`  channel i divisor on bits [i*WIDTH +: WIDTH]
- `load`  input  `CHANNELS`  per-channel strobe; capture that channel's `divisor` slice
- `sync`  input  1  phase-align strobe; used only with `CLKDIV_PHASE_ALIGN_EN`
- `clock_out`  output  `CHANNELS`  divided clocks, registered
- `tick`  output  `CHANNELS`  one-cycle end-of-period strobes, registered

## Operation
- Per channel: counter `cnt` (WIDTH bits), active divisor `D`, pending divisor `P`, flag `pv`.
- Running (enable=1, D ≥ 2): `cnt` counts 0..D-1, then wraps to 0. Output period is exactly D `clock_in` cycles.
- `clock_out[i]` = 1 iff `cnt` ≥ floor(D/2): low for floor(D/2) cycles, then high for ceil(D/2) cycles. D=4: 2 low/2 high; D=5: 2 low/3 high.
- `tick[i]` = 1 exactly in the cycle where `cnt` = D-1.
- `load[i]`: P ← divisor slice, pv ← 1. A later load before the wrap overwrites P (newest wins).
- Update rule: at a wrap with pv=1, D ← P, pv ← 0, and the new period starts at `cnt`=0. If `load` coincides with the wrap cycle, the value loaded in that cycle is applied at that wrap.
- Channel stopped (enable=0, or D < 2): `cnt` held at 0, `clock_out`=0, `tick`=0. While stopped, a load applies D ← slice on the next cycle (no wrap needed).
- Divisor values 0 and 1 are legal to load and put the channel into the stopped state until a divisor ≥ 2 is loaded.
- Priority per cycle: `rst` > enable=0 > `sync` (if compiled in) > normal count/update.

## Timing
- Reset (rst=1 at an edge): `cnt`=0, D=`RESET_DIV`, pv=0, `clock_out`=0, `tick`=0 for all channels; asserting `rst` mid-period discards any pending load.
- First edge with rst=0 and enable=1: `cnt` goes to 1. The first full period after reset release is D cycles, counted from the `cnt`=0 cycle.
- `enable` falling: next cycle `cnt`=0, outputs 0. `enable` rising: the next cycle is `cnt`=1; the period begins at the `cnt`=0 cycle held while enable was low.
- Outputs change only on `clock_in` rising edges, directly from flops; there is no combinational path from inputs to outputs.
- Counter arithmetic is unsigned `WIDTH`-bit; the compare is against D-1, so no overflow occurs for any D ≤ 2^`WIDTH`-1.

## Configuration
- `CLKDIV_PHASE_ALIGN_EN` defined: a `sync`=1 cycle forces, on the next edge, `cnt`=0 in every enabled channel, applies any pending P (pv ← 0), drives `clock_out`=0 and suppresses `tick` in that cycle. All channels with related divisors then stay phase-aligned.
- Not defined: `sync` is ignored (port kept for a stable interface), and no alignment logic is synthesised.

## Test plan
- Reset, then enable ch0 with `RESET_DIV`=4 → `clock_out[0]` repeats 0,0,1,1; `tick[0]` high every 4th cycle, coincident with the last high cycle.
- Load D=5 on ch1 mid-period → the old period completes unchanged; from the wrap onward the output is 2 low/3 high and `tick` fires every 5 cycles.
- Two loads (7, then 6) before a wrap, and a load of 9 in the exact wrap cycle → 6 is discarded in favour of 9; the period becomes 9 at that wrap.
- Load D=1, then D=0 → output stays 0 with no ticks; then load D=3 while stopped → running from the next cycle with 1 low/2 high.
- Drop `enable[2]` mid-period, and separately assert `rst` mid-period with a pending load → outputs go to 0 on the next edge, and the pending load is lost after `rst`.
- With `CLKDIV_PHASE_ALIGN_EN` defined: ch0 D=4 and ch1 D=8 free-running at arbitrary phase, pulse `sync` → both `cnt`=0 on the next edge; thereafter every `tick[1]` coincides with every second `tick[0]`.
